// File: rtl/mux_b_pkg.sv
// Shared definitions for the mux_b scheduler family.
//   LANES / SEL_W : lane count and select width of the shared 4:1 mux_b
//   CNT_W         : bit-counter width (covers QUANTUM up to 16)
//   state_t       : scheduler FSM states
//   onehot4()     : lane index -> one-hot grant vector
package mux_b_pkg;

   localparam int unsigned LANES = 4;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      OUT   = 2'd2
   } state_t;

   function automatic logic [LANES-1:0] onehot4(input logic [SEL_W-1:0] sel);
      onehot4 = 4'(1) << sel;
   endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin picker.
//   req  : request vector
//   ptr  : last-served lane; search starts at ptr+1 and wraps
//   lane : chosen lane (0 when any=0)
//   any  : at least one request present
module rr_arb4
   import mux_b_pkg::*;
(
   input  logic [LANES-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] lane,
   output logic             any
);

   // Walk from farthest (ptr itself) to nearest (ptr+1) so the nearest set bit wins.
   always_comb begin
      logic [SEL_W-1:0] idx;
      idx  = '0;
      lane = '0;
      any  = 1'b0;
      for (int i = 4; i >= 1; i--) begin
         idx = ptr + SEL_W'(i);
         if (req[idx]) begin
            lane = idx;
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_b_sched.sv
// Round-robin scheduler time-sharing one mux_b among four serial requesters.
// Grants a lane (C, G active-low, GNT one-hot), samples Y for QUANTUM cycles
// MSB-first, then presents the word with its lane id on a valid/ready port.
//   CLK, RST_N : clock, asynchronous active-low reset
//   REQ        : per-lane request; dropping it mid-word aborts that grant
//   Y          : mux_b output
//   G, C, GNT  : mux_b enable (active-low), select, one-hot grant
//   DOUT, DID  : assembled word and source lane
//   DVALID     : output valid, held until DREADY
//   DREADY     : consumer ready
module mux_b_sched
   import mux_b_pkg::*;
#(
   parameter int unsigned QUANTUM = 8
)(
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [LANES-1:0]   REQ,
   input  logic               Y,
   output logic               G,
   output logic [SEL_W-1:0]   C,
   output logic [LANES-1:0]   GNT,
   output logic [QUANTUM-1:0] DOUT,
   output logic [SEL_W-1:0]   DID,
   output logic               DVALID,
   input  logic               DREADY
);

   localparam int unsigned SW = QUANTUM - 1;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [SEL_W-1:0]   ptr, ptr_nxt;
   // Holds the first QUANTUM-1 bits; the last bit goes straight from Y into DOUT.
   logic [SW-1:0]      sreg, sreg_nxt;
   logic               g_nxt;
   logic [SEL_W-1:0]   c_nxt;
   logic [LANES-1:0]   gnt_nxt;
   logic [QUANTUM-1:0] dout_nxt;
   logic [SEL_W-1:0]   did_nxt;
   logic               dvalid_nxt;

   logic [SEL_W-1:0]   arb_lane;
   logic               arb_any;

   rr_arb4 u_arb (
      .req  (REQ),
      .ptr  (ptr),
      .lane (arb_lane),
      .any  (arb_any)
   );

   // State and output registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= IDLE;
         cnt    <= '0;
         ptr    <= SEL_W'(3);
         sreg   <= '0;
         G      <= 1'b1;
         C      <= '0;
         GNT    <= '0;
         DOUT   <= '0;
         DID    <= '0;
         DVALID <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         ptr    <= ptr_nxt;
         sreg   <= sreg_nxt;
         G      <= g_nxt;
         C      <= c_nxt;
         GNT    <= gnt_nxt;
         DOUT   <= dout_nxt;
         DID    <= did_nxt;
         DVALID <= dvalid_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      ptr_nxt    = ptr;
      sreg_nxt   = sreg;
      g_nxt      = G;
      c_nxt      = C;
      gnt_nxt    = GNT;
      dout_nxt   = DOUT;
      did_nxt    = DID;
      dvalid_nxt = DVALID;

      case (state)
         IDLE: begin
            g_nxt   = 1'b1;
            gnt_nxt = '0;
            if (arb_any) begin
               c_nxt     = arb_lane;
               g_nxt     = 1'b0;
               gnt_nxt   = onehot4(arb_lane);
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end
         end

         SHIFT: begin
            if (!REQ[C]) begin
               // Requester withdrew: drop the partial word, no delivery.
               g_nxt     = 1'b1;
               gnt_nxt   = '0;
               cnt_nxt   = '0;
               ptr_nxt   = C;
               state_nxt = IDLE;
            end else if (cnt == CNT_W'(QUANTUM - 1)) begin
               dout_nxt   = {sreg, Y};
               g_nxt      = 1'b1;
               gnt_nxt    = '0;
               did_nxt    = C;
               dvalid_nxt = 1'b1;
               ptr_nxt    = C;
               cnt_nxt    = '0;
               state_nxt  = OUT;
            end else begin
               sreg_nxt = SW'({sreg, Y});
               cnt_nxt  = cnt + CNT_W'(1);
            end
         end

         OUT: begin
            if (DREADY) begin
               dvalid_nxt = 1'b0;
               state_nxt  = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mux_b_sched.sv
// Directed self-checking bench for mux_b_sched (QUANTUM=8).
// A behavioural mux_b (Y = G ? 0 : X[C]) closes the loop; the bench drives
// X per lane and checks grants, assembled words, handshake and abort paths.
module tb_mux_b_sched;

   logic       CLK;
   logic       RST_N;
   logic [3:0] REQ;
   logic [3:0] X;
   logic       Y;
   logic       G;
   logic [1:0] C;
   logic [3:0] GNT;
   logic [7:0] DOUT;
   logic [1:0] DID;
   logic       DVALID;
   logic       DREADY;

   int pass_cnt = 0;
   int total    = 0;

   mux_b_sched #(.QUANTUM(8)) dut (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .REQ    (REQ),
      .Y      (Y),
      .G      (G),
      .C      (C),
      .GNT    (GNT),
      .DOUT   (DOUT),
      .DID    (DID),
      .DVALID (DVALID),
      .DREADY (DREADY)
   );

   assign Y = G ? 1'b0 : X[C];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST_N  = 1'b0;
      REQ    = 4'b0000;
      X      = 4'b0000;
      DREADY = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
   endtask

   // Ticks until a grant appears; n returns edges taken (30 = timed out).
   task automatic wait_grant(output int n);
      n = 0;
      while (GNT == 4'b0000 && n < 30) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      @(negedge CLK);
      RST_N  = 1'b0;
      REQ    = 4'b0000;
      X      = 4'b0000;
      DREADY = 1'b0;
      #1;
      total++;
      if ({G, C, GNT, DOUT, DID, DVALID} !== {1'b1, 2'd0, 4'd0, 8'd0, 2'd0, 1'b0})
         $display("FAIL reset_values: got G=%b C=%0d GNT=%b DOUT=%h DID=%0d DVALID=%b, need 1/0/0000/00/0/0",
                  G, C, GNT, DOUT, DID, DVALID);
      else pass_cnt++;
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
      total++;
      if ({G, GNT, DVALID} !== {1'b1, 4'd0, 1'b0})
         $display("FAIL reset_idle: got G=%b GNT=%b DVALID=%b, need 1 0000 0", G, GNT, DVALID);
      else pass_cnt++;
   endtask

   // Lane 0 serial word 1,0,1,1,0,0,1,0 -> B2; DVALID 9 edges after REQ.
   task automatic test_single_word();
      logic [7:0] bits;
      bits = 8'b1011_0010;
      do_reset();
      REQ = 4'b0001;
      tick();
      total++;
      if ({GNT, G, C, DVALID} !== {4'b0001, 1'b0, 2'd0, 1'b0})
         $display("FAIL first_grant: got GNT=%b G=%b C=%0d DVALID=%b, need 0001 0 0 0", GNT, G, C, DVALID);
      else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         X[0] = bits[7-i];
         if (i == 7) begin
            total++;
            if (DVALID !== 1'b0)
               $display("FAIL early_valid: got DVALID=%b after 8 edges, need 0", DVALID);
            else pass_cnt++;
         end
         tick();
      end
      total++;
      if ({DVALID, DOUT, DID, G, GNT} !== {1'b1, 8'hB2, 2'd0, 1'b1, 4'd0})
         $display("FAIL word_b2: got DVALID=%b DOUT=%h DID=%0d G=%b GNT=%b, need 1 b2 0 1 0000",
                  DVALID, DOUT, DID, G, GNT);
      else pass_cnt++;
   endtask

   // Continues from test_single_word: output held under backpressure.
   task automatic test_hold();
      DREADY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if ({DVALID, DOUT, DID, G, GNT} !== {1'b1, 8'hB2, 2'd0, 1'b1, 4'd0})
            $display("FAIL hold_%0d: got DVALID=%b DOUT=%h DID=%0d G=%b GNT=%b, need 1 b2 0 1 0000",
                     i, DVALID, DOUT, DID, G, GNT);
         else pass_cnt++;
      end
      DREADY = 1'b1;
      tick();
      DREADY = 1'b0;
      total++;
      if ({DVALID, GNT} !== {1'b0, 4'd0})
         $display("FAIL accept: got DVALID=%b GNT=%b, need 0 0000", DVALID, GNT);
      else pass_cnt++;
      tick();
      total++;
      if (GNT !== 4'b0001)
         $display("FAIL regrant_after_accept: got GNT=%b, need 0001", GNT);
      else pass_cnt++;
   endtask

   task automatic test_round_robin();
      int n;
      logic [3:0] exp_gnt;
      do_reset();
      REQ    = 4'b1111;
      DREADY = 1'b1;
      for (int k = 0; k < 5; k++) begin
         exp_gnt = 4'b0001 << (k % 4);
         wait_grant(n);
         total++;
         if (n !== ((k == 0) ? 1 : 2))
            $display("FAIL rr_gap_%0d: got %0d edges to grant, need %0d", k, n, (k == 0) ? 1 : 2);
         else pass_cnt++;
         total++;
         if ({GNT, C, G} !== {exp_gnt, 2'(k % 4), 1'b0})
            $display("FAIL rr_grant_%0d: got GNT=%b C=%0d G=%b, need %b %0d 0", k, GNT, C, G, exp_gnt, k % 4);
         else pass_cnt++;
         for (int j = 0; j < 8; j++) tick();
         total++;
         if ({G, GNT, DVALID, DID} !== {1'b1, 4'd0, 1'b1, 2'(k % 4)})
            $display("FAIL rr_done_%0d: got G=%b GNT=%b DVALID=%b DID=%0d, need 1 0000 1 %0d",
                     k, G, GNT, DVALID, DID, k % 4);
         else pass_cnt++;
      end
   endtask

   task automatic test_abort();
      do_reset();
      REQ    = 4'b1100;
      X      = 4'b0100;
      DREADY = 1'b1;
      tick();
      total++;
      if ({GNT, C} !== {4'b0100, 2'd2})
         $display("FAIL abort_grant: got GNT=%b C=%0d, need 0100 2", GNT, C);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) tick();
      REQ = 4'b1000;
      tick();
      total++;
      if ({G, GNT, DVALID, DOUT} !== {1'b1, 4'd0, 1'b0, 8'h00})
         $display("FAIL abort_drop: got G=%b GNT=%b DVALID=%b DOUT=%h, need 1 0000 0 00", G, GNT, DVALID, DOUT);
      else pass_cnt++;
      tick();
      total++;
      if ({GNT, C, G} !== {4'b1000, 2'd3, 1'b0})
         $display("FAIL abort_next: got GNT=%b C=%0d G=%b, need 1000 3 0", GNT, C, G);
      else pass_cnt++;
   endtask

   task automatic test_skip();
      do_reset();
      REQ    = 4'b0001;
      X      = 4'b0101;
      DREADY = 1'b1;
      tick();
      REQ = 4'b0101;
      for (int i = 0; i < 8; i++) tick();
      total++;
      if ({DVALID, DOUT, DID} !== {1'b1, 8'hFF, 2'd0})
         $display("FAIL skip_word0: got DVALID=%b DOUT=%h DID=%0d, need 1 ff 0", DVALID, DOUT, DID);
      else pass_cnt++;
      tick();
      tick();
      total++;
      if (GNT !== 4'b0100)
         $display("FAIL skip_lane1: got GNT=%b, need 0100", GNT);
      else pass_cnt++;
      for (int i = 0; i < 8; i++) tick();
      total++;
      if ({DVALID, DID} !== {1'b1, 2'd2})
         $display("FAIL skip_word2: got DVALID=%b DID=%0d, need 1 2", DVALID, DID);
      else pass_cnt++;
      tick();
      tick();
      total++;
      if (GNT !== 4'b0001)
         $display("FAIL skip_wrap: got GNT=%b, need 0001", GNT);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      do_reset();
      REQ    = 4'b0001;
      X      = 4'b0001;
      DREADY = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) tick();
      tick();
      tick();
      for (int i = 0; i < 3; i++) tick();
      total++;
      if ({DOUT, GNT, G} !== {8'hFF, 4'b0001, 1'b0})
         $display("FAIL pre_reset: got DOUT=%h GNT=%b G=%b, need ff 0001 0", DOUT, GNT, G);
      else pass_cnt++;
      #2;
      RST_N = 1'b0;
      #1;
      total++;
      if ({G, GNT, DVALID, DOUT} !== {1'b1, 4'd0, 1'b0, 8'h00})
         $display("FAIL async_reset: got G=%b GNT=%b DVALID=%b DOUT=%h, need 1 0000 0 00", G, GNT, DVALID, DOUT);
      else pass_cnt++;
      REQ = 4'b1010;
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
      total++;
      if ({GNT, C} !== {4'b0010, 2'd1})
         $display("FAIL post_reset_grant: got GNT=%b C=%0d, need 0010 1", GNT, C);
      else pass_cnt++;
   endtask

   initial begin
      RST_N  = 1'b0;
      REQ    = 4'b0000;
      X      = 4'b0000;
      DREADY = 1'b0;
      test_reset();
      test_single_word();
      test_hold();
      test_round_robin();
      test_abort();
      test_skip();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
